// File: rtl/fb_writer.sv
// Pixel-to-framebuffer writer: clips incoming pixels, queues in-range ones in a
// small FIFO and issues them to the framebuffer arbiter as one request at a time.
module fb_writer #(
  parameter int unsigned FB_W  = 160,
  parameter int unsigned FB_H  = 120,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [11:0] in_color,
  output logic        mem_req,
  output logic [14:0] mem_addr,
  output logic [11:0] mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic [15:0] clip_count,
  output logic [15:0] write_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state, state_nx;
  logic [14:0] addr_q  [DEPTH];
  logic [11:0] color_q [DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        empty, full, in_range, accept, push, pop;
  logic [14:0] push_addr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign in_ready  = !full;
  assign in_range  = (32'(in_x) < FB_W) && (32'(in_y) < FB_H);
  assign accept    = in_valid && in_ready;
  assign push      = accept && in_range;
  assign push_addr = 15'(32'(in_y) * FB_W + 32'(in_x));
  assign mem_req   = (state == REQ);
  assign busy      = !empty || (state == REQ);

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (!empty) pop = 1'b1;
          else        state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr[PW-1:0]]  <= push_addr;
      color_q[wr_ptr[PW-1:0]] <= in_color;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      clip_count  <= '0;
      write_count <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + (PW+1)'(1);
        mem_addr  <= addr_q[rd_ptr[PW-1:0]];
        mem_wdata <= color_q[rd_ptr[PW-1:0]];
      end
      if (accept && !in_range && clip_count != '1)
        clip_count <= clip_count + 16'd1;
      if (mem_req && mem_ack && write_count != '1)
        write_count <= write_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Randomized bench for fb_writer: a pending-pixel queue model checks every
// cycle's outputs, plus directed latency, clip, backpressure and reset cases.
module tb_fb_writer;

  localparam int unsigned FB_W  = 160;
  localparam int unsigned FB_H  = 120;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = '0;
  logic [6:0]  in_y = '0;
  logic [11:0] in_color = '0;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic [15:0] clip_count;
  logic [15:0] write_count;

  fb_writer #(.FB_W(FB_W), .FB_H(FB_H), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_color(in_color),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .busy(busy),
    .clip_count(clip_count), .write_count(write_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted in-range pixel waits in q (in acceptance
  // order) until acked; in_flight marks that q[0] is being offered to memory.
  typedef struct {
    logic [14:0] addr;
    logic [11:0] color;
  } pix_t;

  pix_t        q[$];
  bit          in_flight = 1'b0;
  int          exp_clip = 0;
  int          exp_wr = 0;
  logic [14:0] last_addr = '0;
  bit          rand_ack = 1'b0;

  always @(posedge clk) begin
    #2;
    if (rand_ack) mem_ack = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      in_flight = 1'b0;
      exp_clip  = 0;
      exp_wr    = 0;
    end else begin
      int  queued;
      bit  exp_ready;
      pix_t p;
      queued    = q.size() - int'(in_flight);
      exp_ready = (queued < int'(DEPTH));
      check("busy", busy, (q.size() != 0));
      check("mem_req", mem_req, in_flight);
      check("in_ready", in_ready, exp_ready);
      check("clip_count", clip_count, exp_clip);
      check("write_count", write_count, exp_wr);
      if (in_flight) begin
        check("mem_addr", mem_addr, q[0].addr);
        check("mem_wdata", mem_wdata, q[0].color);
      end
      // Advance the model across the coming rising edge.
      if (in_flight && mem_ack) begin
        last_addr = q[0].addr;
        void'(q.pop_front());
        if (exp_wr < 16'hFFFF) exp_wr++;
        in_flight = (q.size() != 0);
      end else if (!in_flight) begin
        in_flight = (q.size() != 0);
      end
      if (in_valid && exp_ready) begin
        if (int'(in_x) >= int'(FB_W) || int'(in_y) >= int'(FB_H)) begin
          if (exp_clip < 16'hFFFF) exp_clip++;
        end else begin
          p.addr  = 15'(int'(in_y) * int'(FB_W) + int'(in_x));
          p.color = in_color;
          q.push_back(p);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic send(input int x, input int y, input int c);
    bit acc = 1'b0;
    int t = 0;
    in_x = 8'(x); in_y = 7'(y); in_color = 12'(c);
    in_valid = 1'b1;
    while (!acc && t < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit idle = 1'b0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    check("idle_timeout", idle, 1);
  endtask

  initial begin
    int accepted;
    // Reset values while rst is held.
    #2;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_counts", {clip_count, write_count}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single pixel, ack tied high: request appears the second cycle after acceptance.
    mem_ack = 1'b1;
    send(10, 25, 12'hFFF);
    @(negedge clk); check("lat_cycle1_req", mem_req, 0);
    @(negedge clk); check("lat_cycle2_req", mem_req, 1);
    check("single_addr", mem_addr, 4010);
    check("single_data", mem_wdata, 12'hFFF);
    @(negedge clk); check("single_req_drop", mem_req, 0);
    check("single_wcount", write_count, 1);

    // Clipping.
    do_reset();
    send(160, 0, 12'h123);
    send(0, 120, 12'h456);
    send(255, 127, 12'h789);
    repeat (4) @(negedge clk);
    check("clip_count3", clip_count, 3);
    check("clip_wcount0", write_count, 0);
    check("clip_busy0", busy, 0);

    // Backpressure: one pixel held in REQ plus DEPTH queued.
    do_reset();
    mem_ack = 1'b0;
    accepted = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bit acc;
      in_x = 8'(20 + accepted); in_y = 7'(3 + accepted); in_color = 12'(16'h0A0 + accepted);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) accepted++;
    end
    in_valid = 1'b0;
    check("bp_accepted", accepted, DEPTH + 1);
    check("bp_in_ready_low", in_ready, 0);
    mem_ack = 1'b1;
    send(20 + accepted, 3 + accepted, 16'h0A0 + accepted);
    wait_idle(50);
    check("bp_wcount", write_count, 6);
    check("bp_last_addr", last_addr, 8 * 160 + 25);

    // Stall stability is covered cycle by cycle by the model comparisons.
    do_reset();
    mem_ack = 1'b0;
    send(77, 66, 12'hABC);
    repeat (6) @(negedge clk);
    check("stall_req_held", mem_req, 1);
    check("stall_wcount0", write_count, 0);
    @(posedge clk); #1 mem_ack = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_wcount1", write_count, 1);

    // Full rectangle with random ack.
    do_reset();
    rand_ack = 1'b1;
    for (int y = 25; y <= 54; y++)
      for (int x = 10; x <= 99; x++)
        send(x, y, (x * 7 + y * 13) & 12'hFFF);
    wait_idle(200);
    check("rect_wcount", write_count, 2700);
    check("rect_last_addr", last_addr, 8739);
    check("rect_busy0", busy, 0);

    // Random pixels, some out of range, with idle gaps.
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 199), $urandom_range(0, 127), $urandom_range(0, 4095));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    wait_idle(200);
    check("rand_drain_empty", q.size(), 0);

    // Reset mid-burst: one outstanding, three queued.
    do_reset();
    rand_ack = 1'b0;
    @(posedge clk); #1 mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) send(5 + i, 9, 12'h300 + i);
    @(negedge clk);
    check("mid_req_before", mem_req, 1);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("mid_req_drop", mem_req, 0);
    check("mid_counts", {clip_count, write_count}, 0);
    check("mid_busy", busy, 0);
    check("mid_in_ready", in_ready, 1);
    @(posedge clk); #1 rst = 1'b1;
    mem_ack = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_no_stale_wcount", write_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 SHALL have parameter FB_W, default 160, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_H, default 120, framebuffer height in pixels.
REQ-003 SHALL have parameter DEPTH, default 4, pixel FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  in  1  upstream pixel present.
REQ-007 SHALL have port in_ready  out  1  block can accept a pixel.
REQ-008 SHALL have port in_x  in  8  pixel column.
REQ-009 SHALL have port in_y  in  7  pixel row.
REQ-010 SHALL have port in_color  in  12  pixel colour, RGB444.
REQ-011 SHALL have port mem_req  out  1  write request to framebuffer arbiter.
REQ-012 SHALL have port mem_addr  out  15  linear framebuffer word address.
REQ-013 SHALL have port mem_wdata  out  12  colour to write.
REQ-014 SHALL have port mem_ack  in  1  arbiter accepted current write this cycle.
REQ-015 SHALL have port busy  out  1  pixels pending or write outstanding.
REQ-016 SHALL have port clip_count  out  16  pixels dropped by clipping.
REQ-017 SHALL have port write_count  out  16  pixels written (acked).

Function
REQ-018 SHALL transfer a pixel on a rising edge only when in_valid && in_ready.
REQ-019 SHALL drive in_ready = FIFO not full, independent of in_valid and of a same-cycle pop.
REQ-020 SHALL drop (accept but not enqueue) a transferred pixel with in_x >= FB_W or in_y >= FB_H, incrementing clip_count.
REQ-021 SHALL enqueue in-range pixels into the DEPTH-entry FIFO; read/write pointers wrap modulo DEPTH; allow simultaneous push and pop when not full.
REQ-022 SHALL compute mem_addr = in_y*FB_W + in_x, truncated to 15 bits, at enqueue or dequeue (implementer's choice), without changing latency in REQ-025.
REQ-023 SHALL implement write FSM states IDLE and REQ: IDLE -> REQ when FIFO non-empty (pop, load mem_addr/mem_wdata); REQ stays until mem_ack; on mem_ack -> REQ with next popped pixel if FIFO non-empty, else -> IDLE.
REQ-024 SHALL hold mem_req=1 with mem_addr/mem_wdata stable for every cycle in REQ; mem_req=0 in IDLE.
REQ-025 SHALL assert mem_req the second cycle after the edge accepting a pixel into an empty FIFO with FSM in IDLE.
REQ-026 SHALL ignore mem_ack while mem_req=0.
REQ-027 SHALL sustain one write per cycle when mem_ack is held high and FIFO stays non-empty.
REQ-028 SHALL increment write_count on each cycle with mem_req && mem_ack.
REQ-029 SHALL saturate clip_count and write_count at 16'hFFFF.
REQ-030 SHALL drive busy = FIFO non-empty OR state == REQ.
REQ-031 SHALL preserve pixel order: writes issue in acceptance order.

Reset
REQ-032 SHALL, while rst=0, force immediately: FIFO empty, state IDLE, mem_req=0, mem_addr=0, mem_wdata=0, clip_count=0, write_count=0, busy=0, in_ready=1.
REQ-033 SHALL discard queued and outstanding pixels on reset mid-operation; no write issues for them after release.
REQ-034 SHALL accept pixels on the first rising edge after rst deasserts.

Verification
REQ-035 Single pixel (x=10,y=25,color=FFF), mem_ack tied 1 -> mem_req high exactly one cycle, 2 cycles after acceptance, mem_addr=4010, mem_wdata=FFF, write_count=1.
REQ-036 Clip: pixels (160,0),(0,120),(255,127) -> no mem_req, clip_count=3, write_count=0, busy=0.
REQ-037 Backpressure: mem_ack=0, stream 6 pixels -> in_ready low after DEPTH+1 accepted (4 queued, 1 in REQ); release mem_ack -> all 6 written in order, addresses y*160+x.
REQ-038 Stall stability: mem_ack low 5 cycles during REQ -> mem_req, mem_addr, mem_wdata unchanged every cycle, single write_count increment on ack.
REQ-039 Full 90x30 rectangle stream (x 10..99, y 25..54), mem_ack random -> 2700 writes, correct addresses, last addr 54*160+99=8739, busy falls after last ack.
REQ-040 Reset mid-burst: assert rst with 3 queued, 1 outstanding -> mem_req drops same cycle, counters 0, no stale write after release.
